// File: rtl/ring_sequence_checker.sv
// Receiving-end monitor for a one-hot rotating ring counter: validates one-hot
// codes and rotation order, decodes position, acquires lock and counts sequence errors.
module ring_sequence_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3,
    localparam int IW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             err_clr,
    output logic [IW-1:0]    index,
    output logic             onehot_ok,
    output logic [WIDTH-1:0] expected,
    output logic             locked,
    output logic             err_pulse,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_W      = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_COUNT);

    function automatic logic is_onehot(input logic [WIDTH-1:0] code);
        return (code != ZERO_W) && ((code & (code - ONE_W)) == ZERO_W);
    endfunction

    function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] code);
        return {code[0], code[WIDTH-1:1]};
    endfunction

    function automatic logic [IW-1:0] decode(input logic [WIDTH-1:0] code);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int k = 0; k < WIDTH; k++) begin
            if (code[k]) begin
                idx = IW'(k);
            end
        end
        return idx;
    endfunction

    state_t           state_r, state_next_s;
    logic [3:0]       run_r, run_next_s, run_inc_s;
    logic [WIDTH-1:0] last_r, last_next_s;
    logic [WIDTH-1:0] rot_last_s;
    logic             oh_s, match_s, lock_hit_s;

    logic [IW-1:0]    index_r, index_next_s;
    logic             onehot_ok_r, onehot_ok_next_s;
    logic [WIDTH-1:0] expected_r, expected_next_s;
    logic             err_pulse_r, err_pulse_next_s;
    logic [7:0]       err_count_r, err_count_next_s;

    assign oh_s       = is_onehot(ring_in);
    assign rot_last_s = rotate(last_r);
    // Only a one-hot code can match, so a cleared last register never matches.
    assign match_s    = oh_s && (ring_in == rot_last_s);
    assign run_inc_s  = run_r + 4'd1;
    assign lock_hit_s = (run_inc_s == LOCK_TARGET);

    // FSM state and run-length register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= HUNT;
            run_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            run_r   <= run_next_s;
        end
    end

    // Next-state and run-length logic
    always_comb begin
        state_next_s = state_r;
        run_next_s   = run_r;
        if (in_valid) begin
            case (state_r)
                HUNT: begin
                    if (oh_s) begin
                        state_next_s = ACQ;
                        run_next_s   = 4'd0;
                    end else begin
                        state_next_s = HUNT;
                    end
                end
                ACQ: begin
                    if (match_s) begin
                        run_next_s = run_inc_s;
                        if (lock_hit_s) begin
                            state_next_s = LOCK;
                        end else begin
                            state_next_s = ACQ;
                        end
                    end else if (oh_s) begin
                        state_next_s = ACQ;
                        run_next_s   = 4'd0;
                    end else begin
                        state_next_s = HUNT;
                        run_next_s   = 4'd0;
                    end
                end
                LOCK: begin
                    if (match_s) begin
                        state_next_s = LOCK;
                    end else if (oh_s) begin
                        state_next_s = ACQ;
                        run_next_s   = 4'd0;
                    end else begin
                        state_next_s = HUNT;
                        run_next_s   = 4'd0;
                    end
                end
                default: begin
                    state_next_s = HUNT;
                    run_next_s   = 4'd0;
                end
            endcase
        end else begin
            state_next_s = state_r;
            run_next_s   = run_r;
        end
    end

    // Next values of the registered outputs and the last accepted code
    always_comb begin
        last_next_s      = last_r;
        index_next_s     = index_r;
        onehot_ok_next_s = onehot_ok_r;
        expected_next_s  = expected_r;
        err_pulse_next_s = 1'b0;
        err_count_next_s = err_count_r;
        if (in_valid) begin
            onehot_ok_next_s = oh_s;
            if (oh_s) begin
                last_next_s     = ring_in;
                index_next_s    = decode(ring_in);
                expected_next_s = rotate(ring_in);
            end else begin
                last_next_s = last_r;
            end
            if ((state_r == LOCK) && !match_s) begin
                err_pulse_next_s = 1'b1;
            end else begin
                err_pulse_next_s = 1'b0;
            end
        end else begin
            err_pulse_next_s = 1'b0;
        end
        // A clear coinciding with an error leaves that error counted.
        if (err_clr) begin
            err_count_next_s = err_pulse_next_s ? 8'd1 : 8'd0;
        end else if (err_pulse_next_s && (err_count_r != 8'hFF)) begin
            err_count_next_s = err_count_r + 8'd1;
        end else begin
            err_count_next_s = err_count_r;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r      <= ZERO_W;
            index_r     <= {IW{1'b0}};
            onehot_ok_r <= 1'b0;
            expected_r  <= ZERO_W;
            err_pulse_r <= 1'b0;
            err_count_r <= 8'd0;
        end else begin
            last_r      <= last_next_s;
            index_r     <= index_next_s;
            onehot_ok_r <= onehot_ok_next_s;
            expected_r  <= expected_next_s;
            err_pulse_r <= err_pulse_next_s;
            err_count_r <= err_count_next_s;
        end
    end

    assign index     = index_r;
    assign onehot_ok = onehot_ok_r;
    assign expected  = expected_r;
    assign locked    = (state_r == LOCK);
    assign err_pulse = err_pulse_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Directed self-checking bench for ring_sequence_checker with a reference-model scoreboard.
module tb_ring_sequence_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] ring_in = 4'b0000;
    logic       err_clr = 1'b0;
    logic [1:0] index;
    logic       onehot_ok;
    logic [3:0] expected;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0] idx;
        logic       ok;
        logic [3:0] exp_code;
        logic       lck;
        logic       pulse;
        logic [7:0] cnt;
    } obs_t;

    obs_t sb_q[$];

    // reference model state: 0=HUNT 1=ACQ 2=LOCK
    int         m_state = 0;
    int         m_run   = 0;
    logic [3:0] m_last  = 4'b0000;
    logic [1:0] m_index = 2'd0;
    logic       m_ok    = 1'b0;
    logic       m_pulse = 1'b0;
    int         m_cnt   = 0;

    ring_sequence_checker #(.WIDTH(4), .LOCK_COUNT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .ring_in   (ring_in),
        .err_clr   (err_clr),
        .index     (index),
        .onehot_ok (onehot_ok),
        .expected  (expected),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] rot(input logic [3:0] c);
        return {c[0], c[3:1]};
    endfunction

    task automatic model_reset();
        m_state = 0; m_run = 0; m_last = 4'b0000; m_index = 2'd0;
        m_ok = 1'b0; m_pulse = 1'b0; m_cnt = 0;
    endtask

    task automatic model_update(input logic v, input logic [3:0] code, input logic clr);
        logic oh, match, err;
        oh    = ($countones(code) == 1);
        match = oh && (code == rot(m_last));
        err   = 1'b0;
        m_pulse = 1'b0;
        if (v) begin
            m_ok = oh;
            if (m_state == 0) begin
                if (oh) begin m_state = 1; m_run = 0; end
            end else if (m_state == 1) begin
                if (match) begin
                    m_run = m_run + 1;
                    if (m_run == 3) m_state = 2;
                end else if (oh) m_run = 0;
                else begin m_state = 0; m_run = 0; end
            end else begin
                if (!match) begin
                    err = 1'b1;
                    m_run = 0;
                    m_state = oh ? 1 : 0;
                end
            end
            if (oh) begin
                m_last = code;
                case (code)
                    4'b0001: m_index = 2'd0;
                    4'b0010: m_index = 2'd1;
                    4'b0100: m_index = 2'd2;
                    default: m_index = 2'd3;
                endcase
            end
        end
        if (clr) m_cnt = 0;
        if (err) begin
            m_pulse = 1'b1;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.idx = m_index; o.ok = m_ok; o.exp_code = rot(m_last);
        o.lck = (m_state == 2); o.pulse = m_pulse; o.cnt = 8'(m_cnt);
        return o;
    endfunction

    task automatic check_pop(input string tag);
        obs_t e, o;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: scoreboard empty, observed no expectation", tag);
        end else begin
            e = sb_q.pop_front();
            o = '{index, onehot_ok, expected, locked, err_pulse, err_count};
            assert (o === e) else begin
                n_err++;
                $error("FAIL %s: observed idx=%0d ok=%b exp=%b lck=%b pulse=%b cnt=%0d, expected idx=%0d ok=%b exp=%b lck=%b pulse=%b cnt=%0d",
                       tag, o.idx, o.ok, o.exp_code, o.lck, o.pulse, o.cnt,
                       e.idx, e.ok, e.exp_code, e.lck, e.pulse, e.cnt);
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Drive one sample at the falling edge, expect its effect at the next falling edge.
    task automatic step(input logic v, input logic [3:0] code, input logic clr, input string tag);
        in_valid = v; ring_in = code; err_clr = clr;
        model_update(v, code, clr);
        sb_q.push_back(model_obs());
        @(negedge clk);
        check_pop(tag);
    endtask

    task automatic good(input string tag);
        step(1'b1, rot(m_last), 1'b0, tag);
    endtask

    task automatic bad_onehot(input string tag);
        step(1'b1, rot(rot(m_last)), 1'b0, tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_val("reset_index", {6'd0, index}, 8'd0);
        check_val("reset_flags", {3'd0, onehot_ok, expected}, 8'd0);
        check_val("reset_locked_pulse", {6'd0, locked, err_pulse}, 8'd0);
        check_val("reset_count", err_count, 8'd0);

        // initial acquisition
        step(1'b1, 4'b0001, 1'b0, "seq0001");
        check_val("idx_0001", {6'd0, index}, 8'd0);
        step(1'b1, 4'b1000, 1'b0, "seq1000");
        check_val("idx_1000", {6'd0, index}, 8'd3);
        step(1'b1, 4'b0100, 1'b0, "seq0100");
        check_val("idx_0100", {6'd0, index}, 8'd2);
        check_val("not_locked_3rd", {7'd0, locked}, 8'd0);
        step(1'b1, 4'b0010, 1'b0, "seq0010");
        check_val("idx_0010", {6'd0, index}, 8'd1);
        check_val("locked_4th", {7'd0, locked}, 8'd1);

        // one-hot mismatch while locked
        step(1'b1, 4'b0010, 1'b0, "err_onehot");
        check_val("err1_pulse", {7'd0, err_pulse}, 8'd1);
        check_val("err1_count", err_count, 8'd1);
        check_val("err1_unlock", {7'd0, locked}, 8'd0);
        good("relock_a");
        check_val("pulse_one_cycle", {7'd0, err_pulse}, 8'd0);
        good("relock_b");
        good("relock_c");
        check_val("relocked", {7'd0, locked}, 8'd1);

        // non-one-hot while locked
        step(1'b1, 4'b0110, 1'b0, "err_multi");
        check_val("multi_ok", {7'd0, onehot_ok}, 8'd0);
        check_val("multi_pulse", {7'd0, err_pulse}, 8'd1);
        check_val("multi_index_hold", {6'd0, index}, 8'd2);

        // acquisition with in_valid gaps and junk on ring_in
        good("gap_seq0");
        step(1'b0, 4'b1111, 1'b0, "gap1");
        good("gap_seq1");
        repeat (2) step(1'b0, 4'b0110, 1'b0, "gap2");
        good("gap_seq2");
        repeat (3) step(1'b0, 4'b0000, 1'b0, "gap3");
        good("gap_seq3");
        check_val("gap_locked", {7'd0, locked}, 8'd1);
        step(1'b0, 4'b0101, 1'b0, "gap4");
        good("gap_hold");
        check_val("gap_hold_locked", {7'd0, locked}, 8'd1);

        // saturation via repeated error / relock cycles
        for (int i = 0; i < 256; i++) begin
            bad_onehot("sat_err");
            good("sat_g1");
            good("sat_g2");
            good("sat_g3");
        end
        bad_onehot("sat_final");
        check_val("sat_count", err_count, 8'd255);
        check_val("sat_pulse", {7'd0, err_pulse}, 8'd1);
        good("sat_r1");
        good("sat_r2");
        good("sat_r3");

        // clear coinciding with an error
        step(1'b1, rot(rot(m_last)), 1'b1, "clr_err");
        check_val("clr_err_count", err_count, 8'd1);
        check_val("clr_err_pulse", {7'd0, err_pulse}, 8'd1);

        // build err_count up to 5 and relock
        for (int i = 0; i < 4; i++) begin
            good("c5_g1");
            good("c5_g2");
            good("c5_g3");
            bad_onehot("c5_err");
        end
        good("c5_r1");
        good("c5_r2");
        good("c5_r3");
        check_val("pre_rst_count", err_count, 8'd5);
        check_val("pre_rst_locked", {7'd0, locked}, 8'd1);

        // asynchronous reset between clock edges
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_val("arst_index", {6'd0, index}, 8'd0);
        check_val("arst_flags", {3'd0, onehot_ok, expected}, 8'd0);
        check_val("arst_locked_pulse", {6'd0, locked, err_pulse}, 8'd0);
        check_val("arst_count", err_count, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 4'b0000, 1'b0, "post_rst_zero");
        step(1'b1, 4'b1000, 1'b0, "post_rst_hunt");
        check_val("post_rst_expected", {4'd0, expected}, 8'd4);
        good("post_rst_g1");
        good("post_rst_g2");
        check_val("post_rst_not_locked", {7'd0, locked}, 8'd0);
        good("post_rst_g3");
        check_val("post_rst_locked", {7'd0, locked}, 8'd1);

        in_valid = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ring_sequence_checker.md
# ring_sequence_checker

- Receiving-end monitor for the 4-bit one-hot rotating ring counter.
- Samples a ring code stream, checks that each code is one-hot and follows the ring's rotation order, and decodes the active position to a binary index.
- Acquires lock after a run of correct transitions and counts sequence errors once locked.
- Sits downstream of any ring-counter source as a self-check and position decoder.

## Interface
- WIDTH, 4, ring width in bits (≥2); IW = $clog2(WIDTH)
- LOCK_COUNT, 3, consecutive correct transitions required to lock (1..15)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  ring_in sampled on this edge when 1
- ring_in  input  WIDTH  ring code under check
- err_clr  input  1  synchronous clear of err_count
- index  output  IW  binary position of last accepted one-hot code
- onehot_ok  output  1  last sampled code was one-hot
- expected  output  WIDTH  next code predicted from last accepted code
- locked  output  1  sequence lock held
- err_pulse  output  1  one-cycle pulse per sequence error while locked
- err_count  output  8  saturating error count

## Operation
- Rotation order: next = {cur[0], cur[WIDTH-1:1]}. For WIDTH=4 the sequence is 0001→1000→0100→0010→0001.
- One-hot means exactly one bit set. 0000 and multi-bit codes are not one-hot.
- Index decode: bit k set → index=k. Example: 0001→0, 0010→1, 0100→2, 1000→3.
- Internal state: last (WIDTH bits), run (4 bits), and an FSM with states HUNT, ACQ, LOCK.
- When in_valid=0, all state and outputs hold, except err_pulse, which is 0.
- When in_valid=1:
  - onehot_ok is set to the one-hot status of ring_in.
  - If ring_in is one-hot: index is updated and last is set to ring_in.
- HUNT:
  - One-hot sample → ACQ, run=0.
  - Non-one-hot sample → stay in HUNT.
- ACQ:
  - ring_in == rotate(last) → run+1. If run+1 == LOCK_COUNT → LOCK.
  - One-hot mismatch → stay in ACQ, run=0.
  - Non-one-hot → HUNT, run=0.
- LOCK:
  - Match → stay in LOCK.
  - Any mismatch → err_pulse=1 and err_count+1 (saturates at 255).
    - If the sample is one-hot → ACQ, run=0.
    - Otherwise → HUNT.
- Errors are counted only in LOCK. Mismatches in HUNT or ACQ never pulse.
- expected = rotate(last). It is 0 while last=0, i.e. after reset until the first one-hot sample.
- locked = (state == LOCK).
- err_clr=1 sets err_count to 0. If err_clr and a LOCK error occur on the same edge, err_count=1 and err_pulse=1.

## Timing
- All outputs are registered.
- Every effect of the sample taken on edge N is visible after edge N (one-cycle latency).
- Reset values: index=0, onehot_ok=0, expected=0, locked=0, err_pulse=0, err_count=0, FSM=HUNT, last=0, run=0.
- Reset asserted mid-stream immediately clears all state and outputs, with no wait for clk. The first valid sample after release is handled as in HUNT.
- Lock latency: LOCK_COUNT+1 consecutive correct valid samples. With the default of 3, locked rises after the 4th edge.
- Gaps in in_valid do not break a run. Comparison is always against the last accepted one-hot code.
- err_pulse lasts exactly one cycle per erroring sample. Back-to-back errors are impossible because the first error leaves LOCK.
- err_count at 255 plus an error stays at 255, and err_pulse still fires.

## Test plan
- Reset release, then in_valid=1 with 0001,1000,0100,0010 → index 0,3,2,1; locked=1 after the 4th edge; err_count=0.
- While locked, inject 0010 where 0001 is expected → err_pulse=1 for one cycle, err_count=1, FSM=ACQ, locked=0; three further correct codes → locked=1 again.
- While locked, inject 0110 → onehot_ok=0, err_pulse=1, FSM=HUNT; index holds its previous value.
- Correct sequence with in_valid=0 gaps of 1–3 cycles → lock is acquired and held, err_pulse is never asserted.
- Force 256 errors via repeated lock/error cycles → err_count saturates at 255; err_clr on the same edge as an error → err_count=1.
- Assert reset asynchronously between clock edges while locked with err_count=5 → all outputs go to 0 immediately; the first sample after release is treated as in HUNT.
